pipeline_out_fifo: RTL and testbench

//   Elastic output buffer on the downstream side of the common-ready pipeline.

---
 rtl/pipeline_out_fifo_if.sv | 28 ++
 rtl/pipeline_out_fifo.sv | 67 ++++++
 tb/tb_pipeline_out_fifo.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipeline_out_fifo_if.sv
// Handshake bundle for the pipeline output FIFO: upstream push side and downstream show-ahead pop side.
interface pipeline_out_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] u_data;
  logic                  u_valid;
  logic                  u_ready;
  logic [DATA_WIDTH-1:0] d_data;
  logic                  d_valid;
  logic                  d_ready;
  logic [CW-1:0]         d_count;
  logic                  d_afull;

  // Environment side: feeds the upstream words and the consumer's ready.
  modport master (
    output u_data, u_valid, d_ready,
    input  u_ready, d_data, d_valid, d_count, d_afull
  );

  // FIFO side.
  modport slave (
    input  u_data, u_valid, d_ready,
    output u_ready, d_data, d_valid, d_count, d_afull
  );
endinterface

// File: rtl/pipeline_out_fifo.sv
// Elastic show-ahead output buffer behind the common-ready pipeline.
// u_ready is a flop, so consumer stalls never reach the pipeline ready chain combinationally.
module pipeline_out_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_out_fifo_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CW         = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  u_ready_q, u_ready_d;
  logic                  push, pop;

  assign push = bus.u_valid & u_ready_q;
  assign pop  = (count_q != '0) & bus.d_ready;

  // DEPTH is a power of two, so pointer wrap is plain modular increment.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    u_ready_d = (count_d != CW'(DEPTH));
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      u_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      u_ready_q <= u_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.u_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && count_q == CW'(DEPTH)))
        else $error("pipeline_out_fifo: push while full");
      assert (!(pop && count_q == '0))
        else $error("pipeline_out_fifo: pop while empty");
    end
  end

  assign bus.u_ready = u_ready_q;
  assign bus.d_valid = (count_q != '0);
  assign bus.d_data  = mem_q[rd_ptr_q];
  assign bus.d_count = count_q;
  assign bus.d_afull = (count_q >= CW'(AFULL_THRESH));
endmodule

// File: tb/tb_pipeline_out_fifo.sv
// Directed-vector and scoreboard bench for pipeline_out_fifo.
module tb_pipeline_out_fifo;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_out_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  pipeline_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        uv;
    logic [31:0] ud;
    logic        dr;
    logic        ev;
    logic [31:0] ed;
    int          ecnt;
    logic        eaf;
    logic        eur;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic uv, input logic [31:0] ud, input logic dr);
    bus.u_valid = uv;
    bus.u_data  = ud;
    bus.d_ready = dr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic        exp_ur;
  logic        r_uv, r_dr, r_push, r_pop;
  logic [31:0] r_ud;

  initial begin
    // Table: inputs for this cycle, outputs observed this cycle before the edge.
    vecs[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h11, 1'b0, 1'b0, 32'h00, 0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 2, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h11, 3, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 32'h55, 1'b0, 1'b1, 32'h11, 4, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h11, 4, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 3, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 2, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h44, 1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 32'hA5, 1'b1, 1'b0, 32'h00, 0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hA5, 1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 0, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
    step();
    chk("reset_valid", 32'(bus.d_valid), 32'd0);
    chk("reset_count", 32'(bus.d_count), 32'd0);
    chk("reset_afull", 32'(bus.d_afull), 32'd0);
    chk("reset_uready", 32'(bus.u_ready), 32'd0);
    rst_n = 1'b1;

    // Fill, drain, empty-push
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].uv, vecs[i].ud, vecs[i].dr);
      chk($sformatf("vec%0d_valid", i), 32'(bus.d_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 32'(bus.d_count), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_afull", i), 32'(bus.d_afull), 32'(vecs[i].eaf));
      chk($sformatf("vec%0d_uready", i), 32'(bus.u_ready), 32'(vecs[i].eur));
      if (vecs[i].ev) chk($sformatf("vec%0d_data", i), bus.d_data, vecs[i].ed);
      step();
    end

    // Steady streaming at count=2
    drive(1'b1, 32'hB0, 1'b0); step();
    drive(1'b1, 32'hB1, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hB2 + 32'(i), 1'b1);
      chk("stream_count", 32'(bus.d_count), 32'd2);
      chk("stream_data", bus.d_data, 32'hB0 + 32'(i));
      chk("stream_uready", 32'(bus.u_ready), 32'd1);
      step();
    end
    drive(1'b0, 32'h0, 1'b1); step(); step();
    chk("stream_drained", 32'(bus.d_count), 32'd0);

    // Reset mid-flow with three words held
    drive(1'b1, 32'hC0, 1'b0); step();
    drive(1'b1, 32'hC1, 1'b0); step();
    drive(1'b1, 32'hC2, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_rst_count", 32'(bus.d_count), 32'd3);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(bus.d_valid), 32'd0);
    chk("midrst_count", 32'(bus.d_count), 32'd0);
    chk("midrst_uready", 32'(bus.u_ready), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 32'hD0, 1'b1);
    step();
    chk("post_rst_uready", 32'(bus.u_ready), 32'd1);
    chk("post_rst_valid", 32'(bus.d_valid), 32'd0);
    chk("post_rst_count", 32'(bus.d_count), 32'd0);
    step();
    drive(1'b0, 32'h0, 1'b1);
    chk("post_rst_first_valid", 32'(bus.d_valid), 32'd1);
    chk("post_rst_first_data", bus.d_data, 32'hD0);
    chk("post_rst_first_count", 32'(bus.d_count), 32'd1);
    step();
    chk("post_rst_empty", 32'(bus.d_count), 32'd0);

    // Random traffic against a queue scoreboard
    exp_ur = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      r_uv = 1'($urandom_range(0, 1));
      r_dr = 1'($urandom_range(0, 3) != 0 ? (c % 200 < 100) : 1'b1);
      r_ud = $urandom;
      drive(r_uv, r_ud, r_dr);
      chk("rnd_valid", 32'(bus.d_valid), 32'(q.size() != 0));
      chk("rnd_count", 32'(bus.d_count), 32'(q.size()));
      chk("rnd_uready", 32'(bus.u_ready), 32'(exp_ur));
      chk("rnd_afull", 32'(bus.d_afull), 32'(q.size() >= 3));
      if (q.size() != 0) chk("rnd_data", bus.d_data, q[0]);
      r_pop  = (q.size() != 0) && r_dr;
      r_push = r_uv && exp_ur;
      step();
      if (r_pop)  void'(q.pop_front());
      if (r_push) q.push_back(r_ud);
      exp_ur = (q.size() != DEPTH);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
